shift_reg_frame: RTL
====================

// Module: shift_reg_frame
// PURPOSE
//  Parametrised universal shift register; next generation of the 8-bit HOLD/LOAD/LEFT/RIGHT register.
//  Adds generic width, rotate, arithmetic-shift and clear modes, and serial taps at both ends.
//  A frame counter pulses frame_done once every WIDTH shift/rotate operations.
//  Used as the serialiser/deserialiser core for bit-serial links.
// PARAMETERS
//  WIDTH    8   register width in bits; legal range WIDTH >= 2
//  CNT_W    $clog2(WIDTH)   frame counter width; derived, never overridden
// PORTS
//  clk         in   1      system clock; rising edge active
//  nrst        in   1      asynchronous active-low reset
//  D           in   1      serial data in, used by LEFT and RIGHT
//  mode_i      in   3      operation select, decoded below
//  par_i       in   WIDTH  parallel load data
//  P           out  WIDTH  registered parallel output
//  so_msb      out  1      = P[WIDTH-1]; combinational from the register
//  so_lsb      out  1      = P[0]; combinational from the register
//  cnt_o       out  CNT_W  shift operations since the last frame boundary
//  frame_done  out  1      registered 1-cycle pulse on completion of a WIDTH-op frame
// BEHAVIOUR
//  Reset (nrst=0, asynchronous): P=0, cnt_o=0, frame_done=0. Held while nrst=0, regardless of clk and mode_i.
//  Release: outputs first change on the first rising clk edge with nrst=1.
//  Reset mid-frame discards the partial frame.
//  All updates occur on rising clk. One-cycle latency from mode_i/D/par_i to P.
//  mode_i decode (P' is the next value):
//   0 HOLD  P'=P
//   1 LOAD  P'=par_i
//   2 LEFT  P'={P[WIDTH-2:0],D}           (D enters the LSB; the MSB is discarded)
//   3 RIGHT P'={D,P[WIDTH-1:1]}           (D enters the MSB)
//   4 ROTL  P'={P[WIDTH-2:0],P[WIDTH-1]}
//   5 ROTR  P'={P[0],P[WIDTH-1:1]}
//   6 ASR   P'={P[WIDTH-1],P[WIDTH-1:1]}  (sign-preserving)
//   7 CLEAR P'=0
//  Shift ops are modes 2-6.
//  Frame counter:
//   - Shift op with cnt_o<WIDTH-1: cnt_o+1, frame_done'=0.
//   - Shift op with cnt_o==WIDTH-1: cnt_o'=0 (wrap), frame_done'=1.
//   - LOAD or CLEAR: cnt_o'=0, frame_done'=0 (starts a new frame).
//   - HOLD: cnt_o holds, frame_done'=0. HOLD gaps do not break a frame.
//  frame_done is high for exactly one cycle per frame.
//  Back-to-back frames: after a wrap, the next shift op counts as op 1 of the new frame.
//  D is ignored in modes other than 2 and 3. par_i is ignored in modes other than 1.
//  No illegal mode_i values exist: all 8 encodings are defined.
// TESTING (WIDTH=8 unless noted; drive inputs on negedge, check 1.1ns after posedge)
//  1. Reset: nrst=0 with mode_i=1, par_i=8'h77 -> P=0, cnt_o=0, frame_done=0 before and after a clk edge.
//     Release nrst on negedge -> P stays 0.
//  2. LEFT: 8 ops with D=1,0,1,0,1,0,1,0 -> P=8'hAA; frame_done=1 only in the cycle after op 8; cnt_o=0.
//     RIGHT with the same stream -> P=8'h55.
//  3. LOAD 8'h81, then ROTL -> P=8'h03. ROTR x2 -> P=8'hC0. ASR on 8'h80 x3 -> P=8'hF0.
//     Throughout, so_msb/so_lsb track P[7]/P[0].
//  4. Frame counter: 5 LEFT ops, 3 HOLD cycles, 3 LEFT ops -> frame_done pulses once, after op 8.
//     cnt_o is 5 during the HOLDs. LOAD after 4 ops -> cnt_o=0 and no pulse.
//  5. Mid-operation: assert nrst asynchronously between edges during op 4 -> P, cnt_o clear immediately.
//     CLEAR mode with P=8'hFF -> P=0, cnt_o=0.
//  6. WIDTH=5 instance: LOAD 5'b10011, then 5 ROTL -> P=5'b10011 with frame_done after op 5.
//     WIDTH=2 instance: cnt_o wraps 0,1,0.

Source files
------------

// File: rtl/shift_reg_frame.sv
// shift_reg_frame: parametrised universal shift register with serial taps at
// both ends and a frame counter that pulses frame_done once every WIDTH
// shift/rotate operations. Serialiser/deserialiser core for bit-serial links.
//
// There is no handshake. Every rising clk edge applies the operation on
// mode_i, and P shows the result one cycle later. HOLD is the only idle op.
module shift_reg_frame #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             D,
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] par_i,
  output logic [WIDTH-1:0] P,
  output logic             so_msb,
  output logic             so_lsb,
  output logic [CNT_W-1:0] cnt_o,
  output logic             frame_done
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'd0,
    MODE_LOAD  = 3'd1,
    MODE_LEFT  = 3'd2,
    MODE_RIGHT = 3'd3,
    MODE_ROTL  = 3'd4,
    MODE_ROTR  = 3'd5,
    MODE_ASR   = 3'd6,
    MODE_CLEAR = 3'd7
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mode_e            mode;
  logic [WIDTH-1:0] p_next;
  logic [CNT_W-1:0] cnt_next;
  logic             done_next;
  logic             is_shift;

  assign mode   = mode_e'(mode_i);
  assign so_msb = P[WIDTH-1];
  assign so_lsb = P[0];

  // Data path: next register value for the selected operation.
  always_comb begin
    p_next = P;
    case (mode)
      MODE_HOLD:  p_next = P;
      MODE_LOAD:  p_next = par_i;
      MODE_LEFT:  p_next = {P[WIDTH-2:0], D};
      MODE_RIGHT: p_next = {D, P[WIDTH-1:1]};
      MODE_ROTL:  p_next = {P[WIDTH-2:0], P[WIDTH-1]};
      MODE_ROTR:  p_next = {P[0], P[WIDTH-1:1]};
      MODE_ASR:   p_next = {P[WIDTH-1], P[WIDTH-1:1]};
      MODE_CLEAR: p_next = '0;
    endcase
  end

  // Frame counter: shift ops advance and wrap, LOAD/CLEAR restart, HOLD waits.
  always_comb begin
    cnt_next  = cnt_o;
    done_next = 1'b0;
    is_shift  = (mode == MODE_LEFT) || (mode == MODE_RIGHT) ||
                (mode == MODE_ROTL) || (mode == MODE_ROTR) ||
                (mode == MODE_ASR);
    if (is_shift) begin
      if (cnt_o == CNT_LAST) begin
        cnt_next  = '0;
        done_next = 1'b1;
      end else begin
        cnt_next = cnt_o + CNT_W'(1);
      end
    end else if ((mode == MODE_LOAD) || (mode == MODE_CLEAR)) begin
      cnt_next = '0;
    end
  end

  // State register. An asynchronous reset drops any partial frame.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      P          <= '0;
      cnt_o      <= '0;
      frame_done <= 1'b0;
    end else begin
      P          <= p_next;
      cnt_o      <= cnt_next;
      frame_done <= done_next;
    end
  end

endmodule
